// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus-cycle generator: op codes, cycle states
// and the wait-state counter width.
package z80_bus_pkg;

  localparam int WS_W = 3;

  typedef enum logic [2:0] {
    OP_MEMRD = 3'b000,
    OP_MEMWR = 3'b001,
    OP_IORD  = 3'b010,
    OP_IOWR  = 3'b011,
    OP_M1    = 3'b100
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T1H,
    S_T1L,
    S_T2H,
    S_T2L,
    S_TWH,
    S_TWL,
    S_T3H,
    S_T3L,
    S_T4H,
    S_T4L
  } state_e;

  // Codes above M1 are accepted and answered without touching the bus.
  function automatic logic op_is_bus(input logic [2:0] op);
    return op <= OP_M1;
  endfunction

endpackage

// File: rtl/z80_ws_counter.sv
// Wait-state counter: loaded with the forced TW count at T1H, counts TW pairs
// down and merges the external wait_n into a single "leave wait" flag.
module z80_ws_counter
  import z80_bus_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [WS_W-1:0] n,
  input  logic            dec,
  input  logic            wait_n,
  output logic            tw_done
);

  logic [WS_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= n;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Forced waits exhausted and the slave is not stretching the cycle.
  assign tw_done = (cnt == '0) && wait_n;

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus-cycle generator: one command per valid/ready handshake, driven onto
// registered Z80 strobes at half-T-state resolution.
//
// state | meaning
// IDLE  | no cycle; a and d_out hold, d_oe low
// T1H   | address out, strobes high (m1_n low for M1)
// T1L   | mreq_n/rd_n low for memory reads and M1
// T2H   | iorq_n and rd_n/wr_n low for I/O
// T2L   | wr_n low for memory writes; wait_n sampled at its end
// TWH   | wait T-state, first half
// TWL   | wait T-state, second half; wait_n resampled at its end
// T3H   | reads captured at its end; M1 switches to refresh
// T3L   | strobes released (M1: refresh mreq_n low); final state for non-M1
// T4H   | M1 refresh, mreq_n low
// T4L   | M1 refresh, mreq_n high; final state for M1
module z80_bus_master
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int MEM_WS = 0,
  parameter int IO_WS  = 1,
  parameter int RFSH_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [ADDR_W-1:0] a,
  output logic [7:0]        d_out,
  output logic              d_oe,
  input  logic [7:0]        d_in,
  output logic              mreq_n,
  output logic              iorq_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              m1_n,
  output logic              rfsh_n,
  input  logic              wait_n
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [RFSH_W-1:0]   r_q, r_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   a_d;
  logic [7:0]          d_out_d, rdata_d;
  logic                d_oe_d, rsp_d;
  logic                mreq_d, iorq_d, rd_d, wr_d, m1_d, rfsh_d;
  logic                final_st, accept, acc_ok, acc_bad, tw_done;
  logic                is_mem, is_io, is_m1, is_wr;
  logic                in_t1l_tw, in_t2h_tw, in_t2l_tw, in_t3h, in_rfsh, in_bus;
  logic [WS_W-1:0]     ws_n;

  assign final_st  = ((state_q == S_T3L) && (op_q != OP_M1)) || (state_q == S_T4L);
  assign cmd_ready = (state_q == S_IDLE) || final_st;
  assign accept    = cmd_valid && cmd_ready;
  assign acc_ok    = accept && op_is_bus(cmd_op);
  assign acc_bad   = accept && !op_is_bus(cmd_op);

  assign ws_n = ((op_q == OP_IORD) || (op_q == OP_IOWR)) ? WS_W'(IO_WS) : WS_W'(MEM_WS);

  z80_ws_counter u_ws (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == S_T1H),
    .n       (ws_n),
    .dec     (state_q == S_TWH),
    .wait_n  (wait_n),
    .tw_done (tw_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = acc_ok ? S_T1H : S_IDLE;
      S_T1H:        state_d = S_T1L;
      S_T1L:        state_d = S_T2H;
      S_T2H:        state_d = S_T2L;
      S_T2L, S_TWL: state_d = tw_done ? S_T3H : S_TWH;
      S_TWH:        state_d = S_TWL;
      S_T3H:        state_d = S_T3L;
      S_T3L:        state_d = (op_q == OP_M1) ? S_T4H : (acc_ok ? S_T1H : S_IDLE);
      S_T4H:        state_d = S_T4L;
      S_T4L:        state_d = acc_ok ? S_T1H : S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // A rejected-op response can collide with a finishing cycle's response;
  // pend_q defers it by one clk so every accepted command gets its own pulse.
  always_comb begin
    rsp_d  = 1'b0;
    pend_d = pend_q;
    if (final_st) begin
      rsp_d  = 1'b1;
      pend_d = acc_bad;
    end else if (state_q == S_IDLE) begin
      rsp_d  = acc_bad || pend_q;
      pend_d = acc_bad && pend_q;
    end
  end

  always_comb begin
    op_d      = acc_ok ? cmd_op : op_q;
    is_mem    = (op_d == OP_MEMRD) || (op_d == OP_MEMWR);
    is_io     = (op_d == OP_IORD) || (op_d == OP_IOWR);
    is_m1     = (op_d == OP_M1);
    is_wr     = (op_d == OP_MEMWR) || (op_d == OP_IOWR);
    in_t1l_tw = state_d inside {S_T1L, S_T2H, S_T2L, S_TWH, S_TWL};
    in_t2h_tw = state_d inside {S_T2H, S_T2L, S_TWH, S_TWL};
    in_t2l_tw = state_d inside {S_T2L, S_TWH, S_TWL};
    in_t3h    = (state_d == S_T3H);
    in_rfsh   = state_d inside {S_T3H, S_T3L, S_T4H, S_T4L};
    in_bus    = state_d inside {S_T1H, S_T1L, S_T2H, S_T2L, S_TWH, S_TWL, S_T3H, S_T3L};

    mreq_d = !((is_mem && (in_t1l_tw || in_t3h)) ||
               (is_m1 && (in_t1l_tw || (state_d == S_T3L) || (state_d == S_T4H))));
    rd_d   = !(((op_d == OP_MEMRD) && (in_t1l_tw || in_t3h)) ||
               ((op_d == OP_IORD) && (in_t2h_tw || in_t3h)) ||
               (is_m1 && in_t1l_tw));
    wr_d   = !(((op_d == OP_MEMWR) && (in_t2l_tw || in_t3h)) ||
               ((op_d == OP_IOWR) && (in_t2h_tw || in_t3h)));
    iorq_d = !(is_io && (in_t2h_tw || in_t3h));
    m1_d   = !(is_m1 && ((state_d == S_T1H) || in_t1l_tw));
    rfsh_d = !(is_m1 && in_rfsh);
    d_oe_d = is_wr && in_bus;

    a_d = a;
    if (state_d == S_T1H) begin
      a_d = cmd_addr;
    end else if (is_m1 && in_rfsh) begin
      a_d = ADDR_W'(r_q);
    end

    d_out_d = d_out;
    if ((state_d == S_T1H) && is_wr) begin
      d_out_d = cmd_wdata;
    end

    r_d = (state_q == S_T4L) ? r_q + 1'b1 : r_q;

    // M1 samples the opcode while rd_n is still low, one half-T earlier than reads.
    rdata_d = rsp_rdata;
    if ((state_q == S_T3H) && ((op_q == OP_MEMRD) || (op_q == OP_IORD))) begin
      rdata_d = d_in;
    end else if (((state_q == S_T2L) || (state_q == S_TWL)) && tw_done && (op_q == OP_M1)) begin
      rdata_d = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MEMRD;
      r_q       <= '0;
      pend_q    <= 1'b0;
      a         <= '0;
      d_out     <= '0;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mreq_n    <= 1'b1;
      iorq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      m1_n      <= 1'b1;
      rfsh_n    <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      r_q       <= r_d;
      pend_q    <= pend_d;
      a         <= a_d;
      d_out     <= d_out_d;
      d_oe      <= d_oe_d;
      rsp_valid <= rsp_d;
      rsp_rdata <= rdata_d;
      mreq_n    <= mreq_d;
      iorq_n    <= iorq_d;
      rd_n      <= rd_d;
      wr_n      <= wr_d;
      m1_n      <= m1_d;
      rfsh_n    <= rfsh_d;
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Self-checking bench for z80_bus_master: directed cases plus random commands
// checked against a cycle-length / strobe-count model of the Z80 bus rules.
module tb_z80_bus_master;

  localparam int MEM_WS = 0;
  localparam int IO_WS  = 1;
  localparam int RFSH_W = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in = 8'h0;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic        wait_n = 1'b1;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_rdata = 8'h0;
  int          exp_r = 0;

  z80_bus_master #(
    .ADDR_W(16), .MEM_WS(MEM_WS), .IO_WS(IO_WS), .RFSH_W(RFSH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_r = 0;
    exp_rdata = 8'h0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !cmd_ready; k++) step();
    check("cmd_ready", cmd_ready, 1);
  endtask

  // w = number of clks after the accept edge during which wait_n is held low.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] din, input int w);
    int n, extra, p, len, lat;
    int c_mreq, c_iorq, c_rd, c_wr, c_m1, c_rfsh, c_doe;
    int e_mreq, e_iorq, e_rd, e_wr, e_m1, e_rfsh, e_doe;
    bit seen;
    wait_ready();
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; d_in = din; wait_n = 1'b1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;

    n = (op == 3'd2 || op == 3'd3) ? IO_WS : MEM_WS;
    // Samples fall at clk 4+2n, 4+2n+2, ... after accept; each low one adds a TW pair.
    extra = (w >= 4 + 2 * n) ? (w - 4 - 2 * n) / 2 + 1 : 0;
    p = n + extra;
    e_mreq = 0; e_iorq = 0; e_rd = 0; e_wr = 0; e_m1 = 0; e_rfsh = 0; e_doe = 0;
    case (op)
      3'd0: begin len = 6 + 2*p; e_mreq = 4 + 2*p; e_rd = 4 + 2*p; end
      3'd1: begin len = 6 + 2*p; e_mreq = 4 + 2*p; e_wr = 2 + 2*p; e_doe = len; end
      3'd2: begin len = 6 + 2*p; e_iorq = 3 + 2*p; e_rd = 3 + 2*p; end
      3'd3: begin len = 6 + 2*p; e_iorq = 3 + 2*p; e_wr = 3 + 2*p; e_doe = len; end
      3'd4: begin len = 8 + 2*p; e_m1 = 4 + 2*p; e_rd = 3 + 2*p; e_mreq = 5 + 2*p; e_rfsh = 4; end
      default: len = 0;
    endcase

    c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_rfsh = 0; c_doe = 0;
    seen = 1'b0; lat = -1;
    for (int j = 1; j <= 200 && !seen; j++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        lat = j - 1;
      end else begin
        if (j == 1 && op <= 3'd4) check("addr_t1", a, addr);
        if (!mreq_n) c_mreq++;
        if (!iorq_n) c_iorq++;
        if (!rd_n)   c_rd++;
        if (!wr_n)   c_wr++;
        if (!m1_n)   c_m1++;
        if (!rfsh_n) begin
          c_rfsh++;
          check("rfsh_addr", a, exp_r);
        end
        if (d_oe) begin
          c_doe++;
          check("d_out", d_out, wd);
        end
        wait_n = (j <= w) ? 1'b0 : 1'b1;
        step();
      end
    end
    wait_n = 1'b1;
    check("rsp_seen", seen, 1);
    check("latency", lat, len);
    check("mreq_low", c_mreq, e_mreq);
    check("iorq_low", c_iorq, e_iorq);
    check("rd_low", c_rd, e_rd);
    check("wr_low", c_wr, e_wr);
    check("m1_low", c_m1, e_m1);
    check("rfsh_low", c_rfsh, e_rfsh);
    check("doe_high", c_doe, e_doe);
    if (op == 3'd0 || op == 3'd2 || op == 3'd4) exp_rdata = din;
    if (op == 3'd4) exp_r = (exp_r + 1) % (1 << RFSH_W);
    check("rdata", rsp_rdata, exp_rdata);
    step();
    check("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    int acc, npulse, n_rf, nref, t_prev, r;
    bit prev_rf;
    logic [2:0] rop;

    // Reset values
    rst_n = 1'b0;
    step();
    check("rst_strobes", strobes(), 6'h3F);
    check("rst_a", a, 0);
    check("rst_d_out", d_out, 0);
    check("rst_d_oe", d_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();

    // Directed cycles
    run_cmd(3'd0, 16'h1234, 8'h00, 8'hA5, 0);
    run_cmd(3'd1, 16'h8000, 8'h5A, 8'h00, 0);
    run_cmd(3'd2, 16'h00FE, 8'h00, 8'h3C, 8);
    run_cmd(3'd3, 16'h00FF, 8'hC3, 8'h00, 0);
    run_cmd(3'd4, 16'h0000, 8'h00, 8'h76, 0);
    run_cmd(3'd6, 16'h4321, 8'h11, 8'hEE, 0);
    run_cmd(3'd0, 16'hFFFF, 8'h00, 8'h81, 7);

    // Three chained M1 fetches: responses exactly one cycle apart
    wait_ready();
    cmd_op = 3'd4; cmd_addr = 16'h0100; d_in = 8'h00; wait_n = 1'b1; cmd_valid = 1'b1;
    acc = 0; npulse = 0; n_rf = 0; nref = 0; t_prev = 0; prev_rf = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (cmd_valid && cmd_ready) acc++;
      step();
      if (acc == 3) cmd_valid = 1'b0;
      if (rsp_valid) begin
        if (npulse > 0) check("b2b_gap", t - t_prev, 8);
        t_prev = t;
        npulse++;
      end
      if (!rfsh_n) begin
        n_rf++;
        if (prev_rf) begin
          check("b2b_rfsh_addr", a, (exp_r + nref) % (1 << RFSH_W));
          nref++;
        end
      end
      prev_rf = rfsh_n;
    end
    check("b2b_pulses", npulse, 3);
    check("b2b_rfsh_low", n_rf, 12);
    exp_r = (exp_r + 3) % (1 << RFSH_W);
    exp_rdata = 8'h00;

    // Random commands
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      rop = (r == 5) ? 3'($urandom_range(5, 7)) : 3'(r);
      run_cmd(rop, 16'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 12));
    end

    // Refresh counter wrap from reset
    do_reset();
    for (int i = 0; i < 129; i++) run_cmd(3'd4, 16'($urandom), 8'h00, 8'($urandom), 0);

    // Reset during T2L of a memory write
    wait_ready();
    cmd_op = 3'd1; cmd_addr = 16'h2222; cmd_wdata = 8'h99; wait_n = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    check("mid_wr_low", wr_n, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", strobes(), 6'h3F);
    check("mid_rst_doe", d_oe, 0);
    check("mid_rst_a", a, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_rst_no_rsp", rsp_valid, 0);
    end
    rst_n = 1'b1;
    exp_r = 0;
    exp_rdata = 8'h0;
    step();
    check("post_rst_no_rsp", rsp_valid, 0);
    run_cmd(3'd0, 16'h1234, 8'h00, 8'h5C, 0);
    run_cmd(3'd4, 16'h0010, 8'h00, 8'h3E, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
